// File: rtl/seq_det_ctrl.sv
// Run controller for serial pattern detection: arms, sequences and terminates one
// detection run using a programmable Mealy pattern matcher with registered outputs.
module seq_det_ctrl #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             in_valid,
    input  logic             in,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    localparam logic [1:0] ST_NONE   = 2'b00;
    localparam logic [1:0] ST_TARGET = 2'b01;
    localparam logic [1:0] ST_WINDOW = 2'b10;
    localparam logic [1:0] ST_ABORT  = 2'b11;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
    state_t state;

    logic [PAT_W-1:0]  pat_q, hist;
    logic              ovl_q;
    logic [CNT_W-1:0]  tgt_q;
    logic [WIN_W-1:0]  win_q, bit_cnt;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill_inc;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [WIN_W-1:0]  bits_nxt;
    logic              hit, term;
    logic [1:0]        term_code;

    // Match is judged on the post-shift history and post-shift fill
    always_comb begin
        hist_nxt  = {hist[PAT_W-2:0], in};
        fill_inc  = (fill == FULL) ? FULL : fill + 1'b1;
        hit       = in_valid && (hist_nxt == pat_q) && (fill_inc == FULL);
        cnt_nxt   = match_cnt + CNT_W'(hit);
        bits_nxt  = bit_cnt + 1'b1;
        term      = 1'b0;
        term_code = ST_NONE;
        if (abort) begin
            term      = 1'b1;
            term_code = ST_ABORT;
        end else if (in_valid && cnt_nxt == tgt_q) begin
            term      = 1'b1;
            term_code = ST_TARGET;
        end else if (in_valid && win_q != '0 && bits_nxt == win_q) begin
            term      = 1'b1;
            term_code = ST_WINDOW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            match     <= 1'b0;
            match_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= ST_NONE;
            hist      <= '0;
            fill      <= '0;
            bit_cnt   <= '0;
            pat_q     <= '0;
            ovl_q     <= 1'b0;
            tgt_q     <= '0;
            win_q     <= '0;
        end else begin
            match <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= ARM;
                    pat_q     <= cfg_pattern;
                    ovl_q     <= cfg_overlap;
                    tgt_q     <= cfg_target;
                    win_q     <= cfg_window;
                    hist      <= '0;
                    fill      <= '0;
                    bit_cnt   <= '0;
                    match_cnt <= '0;
                    status    <= ST_NONE;
                    busy      <= 1'b1;
                end
                ARM: begin
                    if (abort || tgt_q == '0) begin
                        state  <= DONE;
                        status <= abort ? ST_ABORT : ST_TARGET;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        hist      <= hist_nxt;
                        fill      <= (hit && !ovl_q) ? '0 : fill_inc;
                        bit_cnt   <= bits_nxt;
                        match     <= hit;
                        match_cnt <= cnt_nxt;
                    end
                    if (term) begin
                        state  <= DONE;
                        status <= term_code;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
